// File: rtl/pix_pack_fifo_writer_if.sv
// Bundle for the pixel-stream input, the FIFO write port and the DDR burst notification.
// The master modport is the writer's view; slave is the environment's view.
interface pix_pack_fifo_writer_if #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 128,
   parameter int unsigned CNT_W = 8
);
   logic [IN_W-1:0]  in_data;
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [OUT_W-1:0] fifo_wr_data;
   logic             fifo_wr_en;
   logic             fifo_wr_vld;
   logic             burst_req;
   logic [CNT_W-1:0] burst_len;
   logic             line_done;

   modport master (
      input  in_data, in_valid, in_last, fifo_wr_vld,
      output in_ready, fifo_wr_data, fifo_wr_en, burst_req, burst_len, line_done
   );

   modport slave (
      output in_data, in_valid, in_last, fifo_wr_vld,
      input  in_ready, fifo_wr_data, fifo_wr_en, burst_req, burst_len, line_done
   );
endinterface

// File: rtl/pix_pack_fifo_writer.sv
// Packs RATIO narrow pixels per FIFO word (little-endian, zero-padded at end of line),
// drives the FIFO write handshake and signals completed DDR bursts and line ends.
module pix_pack_fifo_writer #(
   parameter int unsigned IN_W      = 16,
   parameter int unsigned OUT_W     = 128,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned CNT_W     = 8
) (
   input logic                    wr_clk,
   input logic                    wr_rst,
   pix_pack_fifo_writer_if.master bus
);
   localparam int unsigned RATIO  = OUT_W / IN_W;
   localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0) || ((RATIO * IN_W) != OUT_W)) begin : g_bad_ratio
      $error("pix_pack_fifo_writer: OUT_W/IN_W must be an exact power of two >= 2");
   end
   if ((BURST_LEN < 1) || (BURST_LEN > ((2 ** CNT_W) - 1))) begin : g_bad_burst
      $error("pix_pack_fifo_writer: BURST_LEN must lie in 1..2**CNT_W-1");
   end

   logic [OUT_W-1:0]  acc_q, acc_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [OUT_W-1:0]  out_data_q, out_data_d;
   logic              out_pend_q, out_pend_d;
   logic              out_last_q, out_last_d;
   logic [CNT_W-1:0]  bcnt_q, bcnt_d;
   logic              burst_req_q, burst_req_d;
   logic [CNT_W-1:0]  burst_len_q, burst_len_d;
   logic              line_done_q, line_done_d;

   logic              in_ready_c;
   logic              accept;
   logic              xfer;
   logic              complete;
   logic [OUT_W-1:0]  merged;
   logic [CNT_W-1:0]  bcnt_inc;

   // A pending word never blocks input if the FIFO takes it this same cycle.
   assign in_ready_c = ~out_pend_q | bus.fifo_wr_vld;

   always_comb begin
      accept   = bus.in_valid & in_ready_c;
      xfer     = out_pend_q & bus.fifo_wr_vld;
      complete = (lane_q == LANE_W'(RATIO - 1)) | bus.in_last;
      bcnt_inc = bcnt_q + CNT_W'(1);

      // Current pixel dropped into its lane; lanes above it forced to zero as padding.
      merged = acc_q;
      for (int k = 0; k < int'(RATIO); k++) begin
         if (LANE_W'(k) == lane_q) begin
            merged[k*IN_W +: IN_W] = bus.in_data;
         end else if (LANE_W'(k) > lane_q) begin
            merged[k*IN_W +: IN_W] = '0;
         end
      end

      acc_d       = acc_q;
      lane_d      = lane_q;
      out_data_d  = out_data_q;
      out_pend_d  = out_pend_q;
      out_last_d  = out_last_q;
      bcnt_d      = bcnt_q;
      burst_req_d = 1'b0;
      burst_len_d = burst_len_q;
      line_done_d = 1'b0;

      if (xfer) begin
         out_pend_d = 1'b0;
      end

      // A completing word overrides the clear above, giving bubble-free handoff.
      if (accept) begin
         if (complete) begin
            out_data_d = merged;
            out_pend_d = 1'b1;
            out_last_d = bus.in_last;
            lane_d     = '0;
            acc_d      = '0;
         end else begin
            acc_d  = merged;
            lane_d = lane_q + LANE_W'(1);
         end
      end

      // End of line closes the burst early, so an exact multiple yields a single request.
      if (xfer) begin
         if ((bcnt_inc == CNT_W'(BURST_LEN)) || out_last_q) begin
            burst_req_d = 1'b1;
            burst_len_d = bcnt_inc;
            line_done_d = out_last_q;
            bcnt_d      = '0;
         end else begin
            bcnt_d = bcnt_inc;
         end
      end
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         acc_q       <= '0;
         lane_q      <= '0;
         out_data_q  <= '0;
         out_pend_q  <= 1'b0;
         out_last_q  <= 1'b0;
         bcnt_q      <= '0;
         burst_req_q <= 1'b0;
         burst_len_q <= '0;
         line_done_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         lane_q      <= lane_d;
         out_data_q  <= out_data_d;
         out_pend_q  <= out_pend_d;
         out_last_q  <= out_last_d;
         bcnt_q      <= bcnt_d;
         burst_req_q <= burst_req_d;
         burst_len_q <= burst_len_d;
         line_done_q <= line_done_d;
      end
   end

   assign bus.in_ready     = in_ready_c;
   assign bus.fifo_wr_data = out_data_q;
   assign bus.fifo_wr_en   = out_pend_q;
   assign bus.burst_req    = burst_req_q;
   assign bus.burst_len    = burst_len_q;
   assign bus.line_done    = line_done_q;

endmodule
